// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream imem loader that holds the core in reset until an image is loaded
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t          state;
    logic [7:0]      cnt_lo;
    logic [ADDR_W:0] n_words;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic            xfer;
    logic            rearm;
    logic [15:0]     hdr_count;

    assign xfer      = in_valid & in_ready;
    assign rearm     = start && (state == S_DONE || state == S_ERR);
    assign hdr_count = {in_data, cnt_lo};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk <= 8'h00;
        end else if (rearm || state == S_IDLE) begin
            chk <= 8'h00;
        end else if (xfer && (state == S_HDR0 || state == S_HDR1 || state == S_DATA)) begin
            chk <= chk ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            core_rst     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            cnt_lo       <= '0;
            n_words      <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_HDR0;
                    in_ready <= 1'b1;
                end
                S_HDR0: begin
                    if (xfer) begin
                        cnt_lo <= in_data;
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        if (hdr_count > 16'(DEPTH)) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end else if (hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= S_CHK;
`else
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                            core_rst  <= 1'b0;
`endif
                        end else begin
                            n_words  <= hdr_count[ADDR_W:0];
                            byte_idx <= 2'd0;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // in_ready was dropped on the last write edge, so this cycle never takes a byte
                    if (words_loaded == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= S_CHK;
                        in_ready  <= 1'b1;
`else
                        state     <= S_DONE;
                        load_done <= 1'b1;
                        core_rst  <= 1'b0;
`endif
                    end else if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_wdata    <= {in_data, word_buf};
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            words_loaded <= words_loaded + ONE;
                            if (words_loaded + ONE == n_words) begin
                                in_ready <= 1'b0;
                            end
                        end else begin
                            word_buf <= {in_data, word_buf[23:8]};
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if (chk == in_data) begin
                            state     <= S_DONE;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                            core_rst  <= 1'b0;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    // a byte arriving with start in ERR is drained, not decoded
                    if (start) begin
                        state        <= S_HDR0;
                        in_ready     <= 1'b1;
                        core_rst     <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= 2'd0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
// Honours LOADER_CHECKSUM_EN when defined for the build.
module tb_imem_boot_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [7:0]  tx[$];
    logic [31:0] img[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Frames only carry a checksum byte when the feature is built in
    task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (tx[i]) x ^= tx[i];
        tx.push_back(x);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int gap);
        foreach (tx[i]) begin
            send_byte(tx[i]);
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    // Model: an image of words becomes a LE frame plus the writes it must cause
    task automatic send_image();
        int n = img.size();
        tx.delete();
        tx.push_back(n[7:0]);
        tx.push_back(n[15:8]);
        foreach (img[i]) begin
            for (int k = 0; k < 4; k++) tx.push_back(img[i][8*k +: 8]);
            push_wr(i[ADDR_W-1:0], img[i]);
        end
        add_chk();
        send_tx(0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!load_done && !load_err && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) check("done_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_core_rst"}, 32'(core_rst), 1);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_load_err"}, 32'(load_err), 0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 0);
    endtask

    wr_t e;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none required", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                end
            end
            check("core_rst_vs_done", 32'(core_rst), 32'(!load_done));
            if (load_err) check("we_in_err", 32'(mem_we), 0);
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;

        // Two-word image with literal expectations
        push_wr(0, 32'h00500513);
        push_wr(1, 32'h00A00593);
        tx = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        add_chk();
        send_tx(0);
`ifndef LOADER_CHECKSUM_EN
        check("t1_we_last", 32'(mem_we), 1);
        check("t1_done_late", 32'(load_done), 0);
        @(posedge clk); #1;
`endif
        check("t1_done", 32'(load_done), 1);
        check("t1_core_rst", 32'(core_rst), 0);
        check("t1_words", 32'(words_loaded), 2);
        check("t1_in_ready", 32'(in_ready), 0);

        // Empty image
        pulse_start();
        check("t2_rearm_done", 32'(load_done), 0);
        check("t2_rearm_rdy", 32'(in_ready), 1);
        check("t2_rearm_words", 32'(words_loaded), 0);
        tx = '{8'h00, 8'h00};
        add_chk();
        send_tx(0);
        wait_done();
        check("t2_done", 32'(load_done), 1);
        check("t2_core_rst", 32'(core_rst), 0);
        check("t2_words", 32'(words_loaded), 0);

        // Oversized count, draining, start colliding with a byte
        pulse_start();
        tx = '{8'h41, 8'h00};
        send_tx(0);
        check("t3_err", 32'(load_err), 1);
        check("t3_rdy", 32'(in_ready), 1);
        check("t3_core_rst", 32'(core_rst), 1);
        send_byte(8'h55);
        send_byte(8'hAA);
        check("t3_err_sticky", 32'(load_err), 1);
        in_valid = 1'b1; in_data = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
        check("t3_err_clr", 32'(load_err), 0);
        check("t3_rdy_hdr0", 32'(in_ready), 1);

        // Gapped source
        push_wr(0, 32'hDEADBEEF);
        tx = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_chk();
        send_tx(2);
        wait_done();
        check("t4_done", 32'(load_done), 1);
        check("t4_words", 32'(words_loaded), 1);

        // Reset mid-load, then a fresh frame
        pulse_start();
        tx = '{8'h03, 8'h00, 8'h11, 8'h22};
        send_tx(0);
        reset = 1'b1;
        #1;
        check_reset_vals("t5");
        @(posedge clk); #1;
        reset = 1'b0;
        img = '{32'h12345678};
        send_image();
        wait_done();
        check("t5_done", 32'(load_done), 1);
        check("t5_words", 32'(words_loaded), 1);

        // Full-capacity image
        pulse_start();
        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back(32'h9E3779B9 * (i + 1) ^ 32'(i));
        send_image();
        wait_done();
        check("t6_done", 32'(load_done), 1);
        check("t6_words", 32'(words_loaded), DEPTH);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        push_wr(0, 32'h44332211);
        tx = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_tx(0);
        wait_done();
        check("t7_chk_ok", 32'(load_done), 1);
        pulse_start();
        push_wr(0, 32'h44332211);
        tx = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        send_tx(0);
        wait_done();
        check("t7_chk_bad", 32'(load_err), 1);
        check("t7_core_rst", 32'(core_rst), 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("writes_all_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
